// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - hz_state_e : controller FSM state encoding (2 bits)
//   - REG_IDX_W  : architectural register index width
//   - BUBBLE_CTRL: control-bit value loaded into a pipeline register on flush
//   - hz_ctrl_t  : bundle of enables/flushes/PC-select driven by the controller
package pipeline_hazard_ctrl_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int CTRL_BITS_W = 8;

  // Downstream pipeline registers load this on a flush: every control bit
  // cleared, so the slot behaves as a NOP.
  localparam logic [CTRL_BITS_W-1:0] BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_sel_branch;
  } hz_ctrl_t;

  // Control patterns, ordered as the struct fields above.
  localparam hz_ctrl_t CTRL_RUN     = 9'b11111_0000;
  localparam hz_ctrl_t CTRL_FREEZE  = 9'b00000_0000;
  localparam hz_ctrl_t CTRL_BRANCH  = 9'b11111_1111;
  localparam hz_ctrl_t CTRL_LOADUSE = 9'b00111_0100;

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational load-use hazard comparator.
// Ports:
//   id_rs1_i, id_rs2_i : source registers of the instruction in ID
//   id_uses_rs2_i      : ID instruction actually reads rs2
//   idex_memread_i     : instruction in ID/EX is a load
//   idex_rd_i          : destination register of that load
//   load_use_o         : 1 when ID needs the load result before it exists
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_uses_rs2_i,
  input  logic                 idex_memread_i,
  input  logic [REG_IDX_W-1:0] idex_rd_i,
  output logic                 load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = (idex_rd_i == id_rs1_i);
  // rs2 only matters when the instruction really reads it (I-type reuses the field).
  assign rs2_hit = id_uses_rs2_i && (idex_rd_i == id_rs2_i);

  // x0 is hardwired zero, so a load into it never produces a dependency.
  assign load_use_o = idex_memread_i && (idex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush and
// load-use stall for a 5-stage pipeline, plus saturating statistics and a
// sticky memory-timeout flag.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   id_rs1/id_rs2/id_uses_rs2     : ID-stage source operands
//   idex_memread/idex_rd          : load in ID/EX and its destination
//   exmem_branch_taken            : branch in EX/MEM resolved taken
//   exmem_memaccess/dmem_busy     : MEM access pending / memory not ready
//   cnt_clr                       : clear statistics and timeout flag
//   *_en, *_flush, pc_sel_branch  : combinational pipeline controls
//   stall_cycles, flush_events    : saturating counters
//   mem_timeout                   : sticky memory-wait timeout
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs2,
  input  logic                 idex_memread,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic                 exmem_branch_taken,
  input  logic                 exmem_memaccess,
  input  logic                 dmem_busy,
  input  logic                 cnt_clr,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 pc_sel_branch,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events,
  output logic                 mem_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_e         state_q, state_d;
  hz_ctrl_t          ctrl;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              timeout_q;
  logic              timeout_hit;
  logic              mem_wait;
  logic              load_use;

  assign mem_wait = exmem_memaccess && dmem_busy;

  hazard_detect u_hazard_detect (
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_uses_rs2_i  (id_uses_rs2),
    .idex_memread_i (idex_memread),
    .idex_rd_i      (idex_rd),
    .load_use_o     (load_use)
  );

  // Control decode and next state. Priority: memory wait > branch > load-use.
  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = ST_RUN;
    unique case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (mem_wait) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
        end else if (exmem_branch_taken) begin
          ctrl    = CTRL_BRANCH;
          state_d = ST_FLUSH;
        end else if ((state_q == ST_RUN) && load_use) begin
          // The cycle after a flush ID holds a bubble, so no load-use check there.
          ctrl    = CTRL_LOADUSE;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_busy) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
        end else if (exmem_branch_taken) begin
          // A branch held in EX/MEM during the freeze is acted on at release.
          ctrl    = CTRL_BRANCH;
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      ctrl = CTRL_RUN;
    end
  end

  // Wait counter counts frozen cycles, including the cycle the wait is detected.
  always_comb begin
    wait_d      = '0;
    timeout_hit = 1'b0;
    if (state_d == ST_MEM_WAIT) begin
      wait_d      = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      timeout_hit = (wait_d == WAIT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (cnt_clr) begin
        stall_q   <= '0;
        flush_q   <= '0;
        timeout_q <= 1'b0;
      end else begin
        if (!ctrl.pc_en && (stall_q != '1)) begin
          stall_q <= stall_q + 1'b1;
        end
        if (ctrl.pc_sel_branch && (flush_q != '1)) begin
          flush_q <= flush_q + 1'b1;
        end
        if (timeout_hit) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign ifid_en       = ctrl.ifid_en;
  assign idex_en       = ctrl.idex_en;
  assign exmem_en      = ctrl.exmem_en;
  assign memwb_en      = ctrl.memwb_en;
  assign ifid_flush    = ctrl.ifid_flush;
  assign idex_flush    = ctrl.idex_flush;
  assign exmem_flush   = ctrl.exmem_flush;
  assign pc_sel_branch = ctrl.pc_sel_branch;
  assign stall_cycles  = stall_q;
  assign flush_events  = flush_q;
  assign mem_timeout   = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, checked against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [4:0]       id_rs1, id_rs2, idex_rd;
  logic             id_uses_rs2, idex_memread;
  logic             exmem_branch_taken, exmem_memaccess, dmem_busy, cnt_clr;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, pc_sel_branch;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic             mem_timeout;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .id_uses_rs2        (id_uses_rs2),
    .idex_memread       (idex_memread),
    .idex_rd            (idex_rd),
    .exmem_branch_taken (exmem_branch_taken),
    .exmem_memaccess    (exmem_memaccess),
    .dmem_busy          (dmem_busy),
    .cnt_clr            (cnt_clr),
    .pc_en              (pc_en),
    .ifid_en            (ifid_en),
    .idex_en            (idex_en),
    .exmem_en           (exmem_en),
    .memwb_en           (memwb_en),
    .ifid_flush         (ifid_flush),
    .idex_flush         (idex_flush),
    .exmem_flush        (exmem_flush),
    .pc_sel_branch      (pc_sel_branch),
    .stall_cycles       (stall_cycles),
    .flush_events       (flush_events),
    .mem_timeout        (mem_timeout)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses2;
    logic       memread;
    logic [4:0] rd;
    logic       br;
    logic       macc;
    logic       busy;
    logic       clr;
  } stim_t;

  typedef struct packed {
    logic [8:0]       ctrl;   // pc,ifid,idex,exmem,memwb en; ifid,idex,exmem flush; pc_sel
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic             to;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Reference model state: the rules expressed as "are we in a wait",
  // "was last cycle a branch flush", and plain integer counters.
  bit m_in_wait, m_after_br, m_to;
  int m_wait_cnt, m_stall, m_flush;

  task automatic model_reset();
    m_in_wait  = 0;
    m_after_br = 0;
    m_to       = 0;
    m_wait_cnt = 0;
    m_stall    = 0;
    m_flush    = 0;
  endtask

  // Drive one cycle of inputs, predict the response, advance the model.
  task automatic step(input stim_t s);
    bit   lu_pat, frozen, br_go, lu_go;
    exp_t e;
    #1;
    rst                = s.rst;
    id_rs1             = s.rs1;
    id_rs2             = s.rs2;
    id_uses_rs2        = s.uses2;
    idex_memread       = s.memread;
    idex_rd            = s.rd;
    exmem_branch_taken = s.br;
    exmem_memaccess    = s.macc;
    dmem_busy          = s.busy;
    cnt_clr            = s.clr;

    lu_pat = s.memread && (s.rd != 0) && ((s.rd == s.rs1) || (s.uses2 && (s.rd == s.rs2)));
    frozen = 0;
    br_go  = 0;
    lu_go  = 0;
    if (!s.rst) begin
      frozen = m_in_wait ? s.busy : (s.macc && s.busy);
      br_go  = !frozen && s.br;
      lu_go  = !frozen && !s.br && !m_in_wait && !m_after_br && lu_pat;
    end
    e.ctrl  = {!(frozen || lu_go), !(frozen || lu_go), !frozen, !frozen, !frozen,
               br_go, br_go || lu_go, br_go, br_go};
    e.stall = CNT_W'(m_stall);
    e.flush = CNT_W'(m_flush);
    e.to    = m_to;
    sb.push_back(e);

    if (s.rst) begin
      model_reset();
    end else begin
      m_wait_cnt = frozen ? ((m_wait_cnt < MEM_TIMEOUT) ? m_wait_cnt + 1 : m_wait_cnt) : 0;
      if (s.clr) begin
        m_stall = 0;
        m_flush = 0;
        m_to    = 0;
      end else begin
        if ((frozen || lu_go) && (m_stall < CNT_MAX)) m_stall++;
        if (br_go && (m_flush < CNT_MAX)) m_flush++;
        if (frozen && (m_wait_cnt == MEM_TIMEOUT)) m_to = 1;
      end
      m_in_wait  = frozen;
      m_after_br = br_go;
    end
    @(posedge clk);
  endtask

  // Monitor: the controller responds every cycle, so pop one entry per cycle.
  initial begin
    int   txn = 0;
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, pc_sel_branch};
        n_total++;
        if (got !== e.ctrl) begin
          n_bad++;
          $display("FAIL txn %0d ctrl got=%b want=%b", txn, got, e.ctrl);
        end
        n_total++;
        if (stall_cycles !== e.stall) begin
          n_bad++;
          $display("FAIL txn %0d stall_cnt got=%0d want=%0d", txn, stall_cycles, e.stall);
        end
        n_total++;
        if (flush_events !== e.flush) begin
          n_bad++;
          $display("FAIL txn %0d flush_cnt got=%0d want=%0d", txn, flush_events, e.flush);
        end
        n_total++;
        if (mem_timeout !== e.to) begin
          n_bad++;
          $display("FAIL txn %0d timeout got=%b want=%b", txn, mem_timeout, e.to);
        end
        $display("txn %0d ctrl=%b stall=%0d flush=%0d to=%b", txn, got, stall_cycles,
                 flush_events, mem_timeout);
        txn++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; idex_memread = 1'b0;
    idex_rd = '0; exmem_branch_taken = 1'b0; exmem_memaccess = 1'b0;
    dmem_busy = 1'b0; cnt_clr = 1'b0;
    model_reset();
    @(posedge clk);

    // Reset held: enables 1, flushes 0, counters 0.
    step(s); step(s);
    s = '0; step(s); step(s);

    // Load-use on rs1.
    s = '0; s.memread = 1; s.rd = 5; s.rs1 = 5; step(s);
    s = '0; step(s); step(s);

    // x0 never stalls; rs2 match ignored unless rs2 is used.
    s = '0; s.memread = 1; s.rd = 0; s.rs1 = 0; step(s);
    s = '0; s.memread = 1; s.rd = 7; s.rs1 = 3; s.rs2 = 7; s.uses2 = 0; step(s);
    s.uses2 = 1; step(s);
    s = '0; step(s);

    // Branch, then load-use pattern in the FLUSH cycle (suppressed).
    s = '0; s.br = 1; step(s);
    s = '0; s.memread = 1; s.rd = 5; s.rs1 = 5; step(s);
    s = '0; step(s);

    // Memory wait of four busy cycles.
    s = '0; s.macc = 1; s.busy = 1; repeat (4) step(s);
    s.busy = 0; step(s);
    s = '0; step(s);

    // Memory wait + branch + load-use together; branch taken at release.
    s = '0; s.macc = 1; s.busy = 1; s.br = 1; s.memread = 1; s.rd = 9; s.rs1 = 9;
    repeat (3) step(s);
    s.busy = 0; step(s);
    s = '0; s.memread = 1; s.rd = 9; s.rs1 = 9; step(s);
    s = '0; step(s);

    // Clear wins over a same-cycle stall increment.
    s = '0; s.clr = 1; s.memread = 1; s.rd = 4; s.rs2 = 4; s.uses2 = 1; step(s);
    s = '0; step(s);

    // Timeout while busy, then reset mid-wait.
    s = '0; s.macc = 1; s.busy = 1; repeat (11) step(s);
    s.rst = 1; step(s);
    s = '0; step(s); step(s);

    // Timeout again, clear while still frozen, then release.
    s = '0; s.macc = 1; s.busy = 1; repeat (10) step(s);
    s.clr = 1; step(s);
    s.clr = 0; s.busy = 0; step(s);
    s = '0; step(s);

    // Reset during FLUSH, then a load-use must stall normally.
    s = '0; s.br = 1; step(s);
    s = '0; s.rst = 1; step(s);
    s = '0; s.memread = 1; s.rd = 2; s.rs1 = 2; step(s);
    s = '0; step(s);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s.rst     = ($urandom_range(0, 63) == 0);
      s.clr     = ($urandom_range(0, 31) == 0);
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2     = 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom_range(0, 3));
      s.uses2   = 1'($urandom_range(0, 1));
      s.memread = 1'($urandom_range(0, 1));
      s.br      = ($urandom_range(0, 7) == 0);
      s.macc    = ($urandom_range(0, 3) == 0);
      s.busy    = 1'($urandom_range(0, 1));
      step(s);
    end

    @(negedge clk);
    #1;
    n_total++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
